// File: rtl/median_window_feeder_if.sv
// Handshake bundle between the pixel source, the median window feeder and the MEDIAN core.
// With MEDFEED_SOF_EN defined the bundle also carries the PIX_SOF frame-start qualifier.
interface median_window_feeder_if #(
  parameter int SIZE = 8
);
  logic [SIZE-1:0] PIX_IN;
  logic            PIX_VALID;
  logic            PIX_READY;
`ifdef MEDFEED_SOF_EN
  logic            PIX_SOF;
`endif
  logic [SIZE-1:0] MED_DI;
  logic            MED_DSI;
  logic [SIZE-1:0] MED_DO;
  logic            MED_DSO;
  logic [SIZE-1:0] PIX_OUT;
  logic            OUT_VALID;

  // feeder side
  modport slave (
    input  PIX_IN,
    input  PIX_VALID,
`ifdef MEDFEED_SOF_EN
    input  PIX_SOF,
`endif
    input  MED_DO,
    input  MED_DSO,
    output PIX_READY,
    output MED_DI,
    output MED_DSI,
    output PIX_OUT,
    output OUT_VALID
  );

  // pixel source / MEDIAN side
  modport master (
    output PIX_IN,
    output PIX_VALID,
`ifdef MEDFEED_SOF_EN
    output PIX_SOF,
`endif
    output MED_DO,
    output MED_DSO,
    input  PIX_READY,
    input  MED_DI,
    input  MED_DSI,
    input  PIX_OUT,
    input  OUT_VALID
  );
endinterface

// File: rtl/median_window_feeder.sv
// Raster pixel stream -> two line buffers + 3x3 window -> serialised into MEDIAN, one result per
// interior pixel. Define MEDFEED_SOF_EN to add the PIX_SOF frame-restart input.
//
//  state | meaning
//  IDLE  | ready for a pixel; launches a window when an interior pixel is accepted
//  LOAD  | 9 cycles streaming w0..w8 into MEDIAN with DSI high
//  WAIT  | DSI low, waiting for MEDIAN DSO; result captured on DSO
//  DONE  | one-cycle OUT_VALID with the new PIX_OUT
module median_window_feeder #(
  parameter int SIZE  = 8,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic                   CLK,
  input  logic                   nRST,
  median_window_feeder_if.slave  bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   col, col_at;
  logic [RW-1:0]   row, row_at;
  logic [3:0]      ld_cnt;
  logic [SIZE-1:0] pix_out;
  logic [SIZE-1:0] med_di;
  logic            med_dsi, out_valid, pix_ready, xfer, launch;

  logic [SIZE-1:0] lb_top [IMG_W];
  logic [SIZE-1:0] lb_mid [IMG_W];
  logic [SIZE-1:0] win    [9];

  assign pix_ready = (state == IDLE) && nRST;
  assign xfer      = pix_ready && bus.PIX_VALID;

`ifdef MEDFEED_SOF_EN
  // a start-of-frame pixel is stored as (0,0) regardless of where the counters were
  assign col_at = bus.PIX_SOF ? '0 : col;
  assign row_at = bus.PIX_SOF ? '0 : row;
`else
  assign col_at = col;
  assign row_at = row;
`endif

  assign launch = xfer && (row_at >= RW'(2)) && (col_at >= CW'(2));

  always_ff @(posedge CLK) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    med_dsi   = 1'b0;
    med_di    = '0;
    out_valid = 1'b0;
    case (state)
      IDLE: if (launch) state_nx = LOAD;
      LOAD: begin
        med_dsi = 1'b1;
        med_di  = win[ld_cnt];
        if (ld_cnt == 4'd8) state_nx = WAIT;
      end
      // DSO is only honoured here; the stale high from the previous window overlaps LOAD
      WAIT: if (bus.MED_DSO) state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      col     <= '0;
      row     <= '0;
      ld_cnt  <= '0;
      pix_out <= '0;
    end else begin
      if (xfer) begin
        if (col_at == COL_LAST) begin
          col <= '0;
          row <= (row_at == ROW_LAST) ? '0 : row_at + 1'b1;
        end else begin
          col <= col_at + 1'b1;
          row <= row_at;
        end
      end
      ld_cnt <= (state == LOAD) ? ld_cnt + 4'd1 : 4'd0;
      // captured on the DSO cycle so PIX_OUT is already new while OUT_VALID is high
      if (state == WAIT && bus.MED_DSO) pix_out <= bus.MED_DO;
    end
  end

  // line buffers are read-before-write: the window sees the two previous rows at this column
  always_ff @(posedge CLK) begin
    if (xfer) begin
      lb_top[col_at] <= lb_mid[col_at];
      lb_mid[col_at] <= bus.PIX_IN;
      win[0] <= win[1];
      win[1] <= win[2];
      win[2] <= lb_top[col_at];
      win[3] <= win[4];
      win[4] <= win[5];
      win[5] <= lb_mid[col_at];
      win[6] <= win[7];
      win[7] <= win[8];
      win[8] <= bus.PIX_IN;
    end
  end

  assign bus.PIX_READY = pix_ready;
  assign bus.MED_DI    = med_di;
  assign bus.MED_DSI   = med_dsi;
  assign bus.PIX_OUT   = pix_out;
  assign bus.OUT_VALID = out_valid;

endmodule
